// File: rtl/rsb_pkg.sv
// Shared types and defaults for the result scoreboard.
//   rsb_state_t : scoreboard run state (IDLE, WARMUP, CHECK, DONE, HALT)
//   rsb_entry_t : FIFO entry layout {last, data} at the default data width
package rsb_pkg;

  localparam int unsigned RSB_DATA_W = 32;
  localparam int unsigned RSB_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_CHECK,
    ST_DONE,
    ST_HALT
  } rsb_state_t;

  typedef struct packed {
    logic                  last;
    logic [RSB_DATA_W-1:0] data;
  } rsb_entry_t;

endpackage

// File: rtl/rsb_fifo.sv
// Synchronous FIFO for expected-value entries.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   push, push_data     write request and entry; ignored when full
//   pop                 read request; ignored when empty
//   head                entry at the read pointer (valid when !empty)
//   full, empty, level  occupancy status
// Push and pop in the same cycle are both performed when legal.
module rsb_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/result_scoreboard.sv
// In-order scoreboard for the core's Result stream. Expected values are
// preloaded into a FIFO; each valid observed result in CHECK is compared
// against the FIFO head, pass/fail counts are kept and the first failure
// of a run is captured.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   start                        begin a run (honoured in IDLE/DONE/HALT)
//   exp_valid/exp_data/exp_last  expected-value push, exp_ready = !full
//   obs_valid/obs_data           observed result
//   pass_cnt/fail_cnt            saturating compare counters
//   first_err_idx/_exp/_obs      first failure of the run
//   underflow                    sticky: observation with FIFO empty
//   level, busy, done            FIFO occupancy and run status
// Optional feature: define RSB_HALT_ON_MISMATCH_EN to stop the run in HALT
// on the first failure.
module result_scoreboard
  import rsb_pkg::*;
#(
  parameter int unsigned DATA_W = RSB_DATA_W,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned CNT_W  = RSB_CNT_W,
  parameter int unsigned WARMUP = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       exp_valid,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic                       exp_last,
  output logic                       exp_ready,
  input  logic                       obs_valid,
  input  logic [DATA_W-1:0]          obs_data,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic [CNT_W-1:0]           first_err_idx,
  output logic [DATA_W-1:0]          first_err_exp,
  output logic [DATA_W-1:0]          first_err_obs,
  output logic                       underflow,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  rsb_state_t     state;
  logic [WW-1:0]  warm_cnt;
  logic [CNT_W-1:0] cmp_idx;
  logic           err_seen;
  entry_t         push_entry;
  entry_t         head;
  logic           full;
  logic           empty;
  logic           cmp_fire;
  logic           pop;
  logic           mismatch;

  assign push_entry = '{last: exp_last, data: exp_data};
  assign exp_ready  = !full;
  assign cmp_fire   = (state == ST_CHECK) && obs_valid;
  assign pop        = cmp_fire && !empty;
  assign mismatch   = cmp_fire && (empty || (head.data != obs_data));

  rsb_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (exp_valid),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      warm_cnt      <= '0;
      cmp_idx       <= '0;
      err_seen      <= 1'b0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_obs <= '0;
      underflow     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_HALT: begin
          if (start) begin
            warm_cnt      <= '0;
            cmp_idx       <= '0;
            err_seen      <= 1'b0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_obs <= '0;
            underflow     <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            state         <= (WARMUP == 0) ? ST_CHECK : ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          if (warm_cnt == WW'(WARMUP - 1)) state <= ST_CHECK;
          else                             warm_cnt <= warm_cnt + WW'(1);
        end
        ST_CHECK: begin
          if (obs_valid) begin
            if (cmp_idx != '1) cmp_idx <= cmp_idx + CNT_W'(1);
            if (!mismatch) begin
              if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
              if (empty) underflow <= 1'b1;
              if (!err_seen) begin
                err_seen      <= 1'b1;
                first_err_idx <= cmp_idx;
                first_err_exp <= empty ? '0 : head.data;
                first_err_obs <= obs_data;
              end
            end
`ifdef RSB_HALT_ON_MISMATCH_EN
            // A failure wins over a simultaneous last entry: the run halts.
            if (mismatch) begin
              state <= ST_HALT;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (head.last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
`else
            if (!empty && head.last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_scoreboard.sv
module tb_result_scoreboard;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WARMUP = 2;
  localparam int unsigned LW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              exp_valid;
  logic [DATA_W-1:0] exp_data;
  logic              exp_last;
  logic              exp_ready;
  logic              obs_valid;
  logic [DATA_W-1:0] obs_data;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;
  logic [CNT_W-1:0]  first_err_idx;
  logic [DATA_W-1:0] first_err_exp;
  logic [DATA_W-1:0] first_err_obs;
  logic              underflow;
  logic [LW-1:0]     level;
  logic              busy;
  logic              done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  result_scoreboard #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .WARMUP (WARMUP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .exp_valid     (exp_valid),
    .exp_data      (exp_data),
    .exp_last      (exp_last),
    .exp_ready     (exp_ready),
    .obs_valid     (obs_valid),
    .obs_data      (obs_data),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .first_err_idx (first_err_idx),
    .first_err_exp (first_err_exp),
    .first_err_obs (first_err_obs),
    .underflow     (underflow),
    .level         (level),
    .busy          (busy),
    .done          (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic l);
    exp_valid = 1'b1; exp_data = d; exp_last = l;
    tick();
    exp_valid = 1'b0; exp_last = 1'b0;
  endtask

  task automatic obs(input logic [DATA_W-1:0] d);
    obs_valid = 1'b1; obs_data = d;
    tick();
    obs_valid = 1'b0;
  endtask

  // start pulse followed by the warmup cycles; optionally drives obs_valid
  // during warmup to show it is ignored there
  task automatic start_run(input logic obs_in_warmup, input logic [DATA_W-1:0] d);
    start = 1'b1;
    tick();
    start = 1'b0;
    obs_valid = obs_in_warmup; obs_data = d;
    for (int i = 0; i < int'(WARMUP); i++) tick();
    obs_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; exp_valid = 1'b0; exp_data = '0; exp_last = 1'b0;
    obs_valid = 1'b0; obs_data = '0;
    do_reset();

    // reset state
    check("rst_pass",      pass_cnt, 0);
    check("rst_fail",      fail_cnt, 0);
    check("rst_err_idx",   first_err_idx, 0);
    check("rst_err_exp",   first_err_exp, 0);
    check("rst_err_obs",   first_err_obs, 0);
    check("rst_underflow", underflow, 0);
    check("rst_level",     level, 0);
    check("rst_busy",      busy, 0);
    check("rst_done",      done, 0);
    check("rst_ready",     exp_ready, 1);

    // 1: all-match run
    push(1, 0); push(2, 0); push(4, 0); push(5, 1);
    check("t1_level", level, 4);
    start_run(0, 0);
    check("t1_busy", busy, 1);
    obs(1);
    check("t1_latency_pass", pass_cnt, 1);
    obs(2); obs(4); obs(5);
    check("t1_pass",  pass_cnt, 4);
    check("t1_fail",  fail_cnt, 0);
    check("t1_done",  done, 1);
    check("t1_busy0", busy, 0);
    check("t1_level0", level, 0);

    // 2: one mismatch mid-run, restart from DONE
    push(32'h3, 0); push(32'hffff_fffe, 0); push(32'h0, 1);
    start_run(0, 0);
    check("t2_clr_pass", pass_cnt, 0);
    obs(32'h3); obs(32'hffff_ffff); obs(32'h0);
`ifdef RSB_HALT_ON_MISMATCH_EN
    check("t2_pass", pass_cnt, 1);
    check("t2_level", level, 1);
`else
    check("t2_pass", pass_cnt, 2);
    check("t2_level", level, 0);
`endif
    check("t2_fail",    fail_cnt, 1);
    check("t2_err_idx", first_err_idx, 1);
    check("t2_err_exp", first_err_exp, 32'hffff_fffe);
    check("t2_err_obs", first_err_obs, 32'hffff_ffff);
    check("t2_done",    done, 1);

    // 3: underflow on empty FIFO
    do_reset();
    start_run(0, 0);
    obs(32'h30);
    check("t3_underflow", underflow, 1);
    check("t3_fail",      fail_cnt, 1);
    check("t3_pass",      pass_cnt, 0);
    check("t3_err_idx",   first_err_idx, 0);
    check("t3_err_exp",   first_err_exp, 0);
    check("t3_err_obs",   first_err_obs, 32'h30);
`ifdef RSB_HALT_ON_MISMATCH_EN
    check("t3_done", done, 1);
`else
    check("t3_busy", busy, 1);
`endif

    // 4: full FIFO, blocked pushes, push+pop at the full boundary
    do_reset();
    exp_valid = 1'b1; exp_last = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      exp_data = DATA_W'(i);
      tick();
    end
    check("t4_full_level", level, DEPTH);
    check("t4_full_ready", exp_ready, 0);
    // not in CHECK: no pop, push blocked
    exp_data = 32'hdead; obs_valid = 1'b1; obs_data = 0;
    tick();
    exp_valid = 1'b0; obs_valid = 1'b0;
    check("t4_idle_level", level, DEPTH);
    check("t4_idle_pass",  pass_cnt, 0);
    start_run(0, 0);
    // full: pop happens, push of beef rejected
    exp_valid = 1'b1; exp_data = 32'hbeef; obs_valid = 1'b1; obs_data = 0;
    tick();
    check("t4_fullpop_level", level, DEPTH - 1);
    check("t4_fullpop_ready", exp_ready, 1);
    // not full: push and pop both happen
    exp_data = 100; exp_last = 1'b1; obs_data = 1;
    tick();
    exp_valid = 1'b0; exp_last = 1'b0; obs_valid = 1'b0;
    check("t4_pushpop_level", level, DEPTH - 1);
    for (int i = 2; i < int'(DEPTH); i++) obs(DATA_W'(i));
    obs(100);
    check("t4_pass",  pass_cnt, DEPTH + 1);
    check("t4_fail",  fail_cnt, 0);
    check("t4_done",  done, 1);
    check("t4_level", level, 0);

    // 5: obs ignored during warmup; reset mid-CHECK wins over start/push
    do_reset();
    push(7, 0); push(8, 1);
    start_run(1, 7);
    check("t5_warm_pass",  pass_cnt, 0);
    check("t5_warm_fail",  fail_cnt, 0);
    check("t5_warm_level", level, 2);
    obs(7);
    check("t5_check_pass", pass_cnt, 1);
    reset = 1'b1; start = 1'b1; exp_valid = 1'b1; exp_data = 9;
    tick();
    reset = 1'b0; start = 1'b0; exp_valid = 1'b0;
    check("t5_rst_pass",  pass_cnt, 0);
    check("t5_rst_level", level, 0);
    check("t5_rst_ready", exp_ready, 1);
    check("t5_rst_busy",  busy, 0);
    check("t5_rst_done",  done, 0);
    tick();
    check("t5_rst_idle", busy, 0);

    // 6: mismatch at idx 0 then matching obs
    push(32'h10, 0); push(32'h11, 1);
    start_run(0, 0);
    obs(32'h99); obs(32'h11);
    tick(); tick();
`ifdef RSB_HALT_ON_MISMATCH_EN
    check("t6_pass",  pass_cnt, 0);
    check("t6_level", level, 1);
`else
    check("t6_pass",  pass_cnt, 1);
    check("t6_level", level, 0);
`endif
    check("t6_fail",    fail_cnt, 1);
    check("t6_err_idx", first_err_idx, 0);
    check("t6_err_obs", first_err_obs, 32'h99);
    check("t6_done",    done, 1);
    // restart clears run state
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_restart_fail", fail_cnt, 0);
    check("t6_restart_err",  first_err_obs, 0);
    check("t6_restart_busy", busy, 1);
    check("t6_restart_done", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
